// File: rtl/tile_blit_engine.sv
// tile_blit_engine: queued sprite-tile copier. CPU commands arrive over an
// Avalon-MM slave into a FIFO; a streaming engine copies one TILE x TILE sprite
// from ROM into the framebuffer at one pixel per clock, with an optional
// transparent colour key. Completion is reported by a counter, an interrupt and
// a sticky bounds-error flag.
//
// Handshake: a CMD write (slave_write with slave_address 0) is accepted on the
// clock edge where slave_waitrequest is low; while slave_waitrequest is high
// the master holds address, data and slave_write stable.
module tile_blit_engine #(
    parameter int TILE       = 29,
    parameter int GRID_X     = 22,
    parameter int GRID_Y     = 16,
    parameter int FB_W       = 640,
    parameter int FB_H       = 480,
    parameter int PIX_W      = 8,
    parameter int NUM_TYPES  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic [3:0]                             slave_address,
    input  logic                                   slave_read,
    output logic [31:0]                            slave_readdata,
    input  logic                                   slave_write,
    input  logic [31:0]                            slave_writedata,
    output logic                                   slave_waitrequest,
    output logic [$clog2(NUM_TYPES*TILE*TILE)-1:0] sprite_addr,
    input  logic [PIX_W-1:0]                       sprite_rddata,
    output logic [$clog2(FB_W*FB_H)-1:0]           fb_addr,
    output logic [PIX_W-1:0]                       fb_wrdata,
    output logic                                   fb_wren,
    output logic                                   busy,
    output logic                                   irq
);
    localparam int SA_W = $clog2(NUM_TYPES*TILE*TILE);
    localparam int FA_W = $clog2(FB_W*FB_H);
    localparam int RC_W = $clog2(TILE + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [RC_W-1:0] LAST = RC_W'(TILE - 1);
    localparam logic [5:0]      GX   = 6'(GRID_X);
    localparam logic [5:0]      GY   = 6'(GRID_Y);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    state_t state_q, state_d;

    // Bus decode
    logic wr_cmd, wr_ctrl, wr_status, wr_done, flush, push, pop, cmd_bad, drain_done;
    logic fifo_empty, fifo_full, head_bad;
    logic [16:0] fifo_mem [FIFO_DEPTH];
    logic [16:0] head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fill;

    // Latched command and scan position
    logic [4:0] cmd_x, cmd_y;
    logic [5:0] cmd_type;
    logic cmd_key_en;
    logic [RC_W-1:0] row_q, col_q, row_d, col_d;
    logic wr_valid;

    // CPU-visible registers
    logic irq_en, err_sticky, irq_pending;
    logic [PIX_W-1:0] key;
    logic [31:0] done_cnt;

    assign wr_cmd    = slave_write && (slave_address == 4'd0);
    assign wr_ctrl   = slave_write && (slave_address == 4'd1);
    assign wr_status = slave_write && (slave_address == 4'd2);
    assign wr_done   = slave_write && (slave_address == 4'd3);
    assign flush     = wr_ctrl && slave_writedata[1];

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];
    assign head_bad   = ({1'b0, head[4:0]} >= GX) || ({1'b0, head[9:5]} >= GY);

    assign slave_waitrequest = wr_cmd && fifo_full;
    assign push = wr_cmd && !fifo_full && !flush;
    assign busy = (state_q != IDLE) || !fifo_empty;
    assign irq  = irq_pending && irq_en;

    // Command storage; contents need no reset, only the pointers do
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= slave_writedata[16:0];
    end

    // FIFO pointers and fill level; flush drops everything still queued
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + CW'(push) - CW'(pop);
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: pop in IDLE, scan in RUN, retire the final write in DRAIN
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        cmd_bad    = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop = 1'b1;
                    if (head_bad) cmd_bad = 1'b1;
                    else          state_d = RUN;
                end
            end
            RUN: begin
                if (row_q == LAST && col_q == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                drain_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, row/col scan and the one-cycle write pipeline behind the ROM
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cmd_x      <= '0;
            cmd_y      <= '0;
            cmd_type   <= '0;
            cmd_key_en <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            row_d      <= '0;
            col_d      <= '0;
            wr_valid   <= 1'b0;
        end else begin
            if (pop) begin
                cmd_x      <= head[4:0];
                cmd_y      <= head[9:5];
                cmd_type   <= head[15:10];
                cmd_key_en <= head[16];
                row_q      <= '0;
                col_q      <= '0;
            end else if (state_q == RUN) begin
                if (col_q == LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            wr_valid <= (state_q == RUN);
            row_d    <= row_q;
            col_d    <= col_q;
        end
    end

    // ROM address: widen every operand before multiplying so nothing truncates
    always_comb begin
        sprite_addr = '0;
        if (state_q == RUN)
            sprite_addr = SA_W'(cmd_type) * SA_W'(TILE*TILE) + SA_W'(row_q) * SA_W'(TILE)
                        + SA_W'(col_q);
    end

    // Framebuffer write port, one stage behind the ROM; keyed pixels are skipped
    always_comb begin
        fb_addr   = '0;
        fb_wrdata = '0;
        fb_wren   = 1'b0;
        if (wr_valid) begin
            fb_addr   = (FA_W'(cmd_y) * FA_W'(TILE) + FA_W'(row_d)) * FA_W'(FB_W)
                      + FA_W'(cmd_x) * FA_W'(TILE) + FA_W'(col_d);
            fb_wrdata = sprite_rddata;
            fb_wren   = !(cmd_key_en && (sprite_rddata == key));
        end
    end

    // CPU registers; hardware set beats CPU clear, CPU clear beats increment
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            irq_en      <= 1'b0;
            key         <= '0;
            err_sticky  <= 1'b0;
            irq_pending <= 1'b0;
            done_cnt    <= '0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= slave_writedata[0];
                key    <= slave_writedata[8 +: PIX_W];
            end
            if (pop && cmd_bad)                     err_sticky <= 1'b1;
            else if (wr_status && slave_writedata[3]) err_sticky <= 1'b0;
            if (drain_done && fifo_empty)             irq_pending <= 1'b1;
            else if (wr_status && slave_writedata[4]) irq_pending <= 1'b0;
            if (wr_done)         done_cnt <= '0;
            else if (drain_done) done_cnt <= done_cnt + 32'd1;
        end
    end

    // Zero-latency register read mux
    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                4'd1: begin
                    slave_readdata[0]          = irq_en;
                    slave_readdata[8 +: PIX_W] = key;
                end
                4'd2: begin
                    slave_readdata[0]    = busy;
                    slave_readdata[1]    = fifo_empty;
                    slave_readdata[2]    = fifo_full;
                    slave_readdata[3]    = err_sticky;
                    slave_readdata[4]    = irq_pending;
                    slave_readdata[11:8] = 4'(fill);
                end
                4'd3:    slave_readdata = done_cnt;
                default: slave_readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_blit_engine.sv
// Directed bench for tile_blit_engine with a framebuffer-write scoreboard.
module tb_tile_blit_engine;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] slave_address = '0;
  logic slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic slave_waitrequest;
  logic [9:0] sprite_addr;
  logic [7:0] sprite_rddata = '0;
  logic [7:0] fb_addr;
  logic [7:0] fb_wrdata;
  logic fb_wren;
  logic busy;
  logic irq;

  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int wr_seen = 0;
  int irq_busy = 0;

  tile_blit_engine #(
    .TILE(4), .GRID_X(4), .GRID_Y(4), .FB_W(16), .FB_H(16),
    .PIX_W(8), .NUM_TYPES(64), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .resetn(resetn),
    .slave_address(slave_address), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
    .sprite_addr(sprite_addr), .sprite_rddata(sprite_rddata),
    .fb_addr(fb_addr), .fb_wrdata(fb_wrdata), .fb_wren(fb_wren),
    .busy(busy), .irq(irq)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // sprite ROM model: ROM[i] = i mod 256, one-cycle read latency
  always @(posedge clock) sprite_rddata <= sprite_addr[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every framebuffer write must match the head of exp_q
  always @(negedge clock) begin
    if (fb_wren) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL fb_unexpected observed addr=%0d data=%0d expected=no write", fb_addr, fb_wrdata);
      end else begin
        check("fb_write", {16'd0, fb_addr, fb_wrdata}, {16'd0, exp_q.pop_front()});
      end
    end
    if (irq && busy) irq_busy++;
  end

  function automatic logic [31:0] cmd_word(input int x, input int y, input int t, input int k);
    return 32'((k << 16) | (t << 10) | (y << 5) | x);
  endfunction

  // expected writes of one blit, straight from the address/data definition
  task automatic push_blit(input int x, input int y, input int t, input int k, input int key);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int d;
        int a;
        d = (t * 16 + r * 4 + c) % 256;
        a = (y * 4 + r) * 16 + x * 4 + c;
        if (!(k == 1 && d == key)) exp_q.push_back({a[7:0], d[7:0]});
      end
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clock);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    #1;
    while (slave_waitrequest && waits < 200) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (waits >= 200) begin
      n_vec++;
      n_err++;
      $error("FAIL wr_timeout observed=waitrequest held expected=accepted");
    end
    @(posedge clock);
    #1;
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clock);
    slave_address = a;
    slave_read = 1'b1;
    #1;
    d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic send_cmd(input int x, input int y, input int t, input int k, input int key,
                          output int waits);
    push_blit(x, y, t, k, key);
    bus_write(4'd0, cmd_word(x, y, t, k), waits);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      n_vec++;
      n_err++;
      $error("FAIL idle_timeout observed=busy expected=idle");
    end
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int w;
    int waits[6];
    int base;
    int n;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_wren", 32'(fb_wren), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_data", 32'(fb_wrdata), 0);
    check("rst_sprite_addr", 32'(sprite_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_waitreq", 32'(slave_waitrequest), 0);
    check("rst_readdata", slave_readdata, 0);
    @(negedge clock);
    resetn = 1'b1;
    bus_read(4'd1, d); check("rst_ctrl", d, 32'h0);
    bus_read(4'd3, d); check("rst_done", d, 32'h0);
    bus_read(4'd2, d); check("rst_status", d, 32'h2);

    // 1: basic blit
    send_cmd(1, 2, 3, 0, 0, w);
    wait_idle();
    check("t1_q_empty", 32'(exp_q.size()), 0);
    bus_read(4'd3, d); check("t1_done", d, 32'd1);
    bus_read(4'd2, d); check("t1_status", d, 32'h12);
    check("t1_irq_masked", 32'(irq), 0);

    // 2: transparency with key 0x32
    bus_write(4'd1, 32'h3200, w);
    bus_read(4'd1, d); check("t2_ctrl", d, 32'h3200);
    base = wr_seen;
    send_cmd(0, 0, 3, 1, 8'h32, w);
    wait_idle();
    check("t2_q_empty", 32'(exp_q.size()), 0);
    check("t2_writes", 32'(wr_seen - base), 32'd15);
    bus_read(4'd3, d); check("t2_done", d, 32'd2);

    // 3: FIFO full, back-pressure, single irq at the end
    bus_write(4'd3, 32'h0, w);
    bus_write(4'd2, 32'h10, w);
    bus_write(4'd1, 32'h3201, w);
    bus_read(4'd2, d); check("t3_status0", d, 32'h2);
    check("t3_irq0", 32'(irq), 0);
    irq_busy = 0;
    send_cmd(0, 0, 0, 0, 0, waits[0]);
    send_cmd(1, 1, 5, 0, 0, waits[1]);
    send_cmd(2, 3, 10, 0, 0, waits[2]);
    send_cmd(3, 0, 63, 0, 0, waits[3]);
    send_cmd(0, 3, 7, 0, 0, waits[4]);
    bus_read(4'd2, d); check("t3_status_full", d, 32'h405);
    send_cmd(3, 3, 20, 0, 0, waits[5]);
    for (int i = 0; i < 5; i++) check("t3_no_wait", 32'(waits[i]), 0);
    check("t3_wait6", 32'(waits[5] > 0), 1);
    wait_idle();
    check("t3_q_empty", 32'(exp_q.size()), 0);
    bus_read(4'd3, d); check("t3_done", d, 32'd6);
    check("t3_irq", 32'(irq), 1);
    check("t3_irq_early", 32'(irq_busy), 0);

    // 4: bounds error
    base = wr_seen;
    bus_write(4'd0, cmd_word(4, 0, 1, 0), w);
    repeat (5) @(negedge clock);
    check("t4_writes", 32'(wr_seen - base), 0);
    bus_read(4'd2, d); check("t4_status_err", d, 32'h1A);
    bus_read(4'd3, d); check("t4_done", d, 32'd6);
    bus_write(4'd2, 32'h8, w);
    bus_read(4'd2, d); check("t4_status_clr", d, 32'h12);

    // 5: flush during the first of three blits
    bus_write(4'd2, 32'h10, w);
    bus_write(4'd3, 32'h0, w);
    send_cmd(2, 1, 9, 0, 0, w);
    bus_write(4'd0, cmd_word(1, 1, 1, 0), w);
    bus_write(4'd0, cmd_word(2, 2, 2, 0), w);
    bus_read(4'd2, d); check("t5_status_q", d, 32'h201);
    bus_write(4'd1, 32'h3, w);
    bus_read(4'd2, d); check("t5_status_flush", d, 32'h3);
    wait_idle();
    repeat (20) @(negedge clock);
    check("t5_q_empty", 32'(exp_q.size()), 0);
    bus_read(4'd3, d); check("t5_done", d, 32'd1);
    bus_read(4'd2, d); check("t5_status", d, 32'h12);

    // 6: reset in the middle of a blit
    base = wr_seen;
    send_cmd(1, 1, 4, 0, 0, w);
    n = 0;
    while (wr_seen < base + 7 && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("t6_reached_px7", 32'(wr_seen - base), 32'd7);
    resetn = 1'b0;
    #1;
    check("t6_wren", 32'(fb_wren), 0);
    check("t6_fb_addr", 32'(fb_addr), 0);
    check("t6_fb_data", 32'(fb_wrdata), 0);
    check("t6_sprite_addr", 32'(sprite_addr), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_irq", 32'(irq), 0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (30) @(negedge clock);
    check("t6_no_writes", 32'(wr_seen - base), 32'd7);
    bus_read(4'd3, d); check("t6_done", d, 32'd0);
    bus_read(4'd2, d); check("t6_status", d, 32'h2);
    bus_read(4'd1, d); check("t6_ctrl", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
